// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : cdb_arbiter (with cdb_pkg packet definition)
// Purpose  : round-robin grant of up to 3 FU results onto the 3-lane CDB.
//            Optional macro CDB_BRANCH_PRIO_EN gives FU 0 fixed lane-0 priority.
// Revision : 1.0
// =====================================================================

package cdb_pkg;
    localparam int ROB_TAG_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      value;
        logic                 take_branch;
        logic [XLEN-1:0]      NPC;
        logic                 halt;
    } CDB_ROB_PACKET;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash_flag,
    input  logic [NUM_FU-1:0]              fu_valid,
    input  CDB_ROB_PACKET [NUM_FU-1:0]     fu_packet,
    output logic [NUM_FU-1:0]              fu_ready,
    output CDB_ROB_PACKET [2:0]            CDB_packet_out
);

    localparam int                CDB_LANES  = 3;
    localparam int                PTR_W      = $clog2(NUM_FU);
    localparam logic [PTR_W:0]    NUM_FU_EXT = (PTR_W+1)'(NUM_FU);
    localparam logic [PTR_W-1:0]  LAST_FU    = PTR_W'(NUM_FU - 1);

    logic [PTR_W-1:0]               rr_ptr_q;
    logic [PTR_W-1:0]               rr_ptr_d;
    CDB_ROB_PACKET [CDB_LANES-1:0]  cdb_q;
    CDB_ROB_PACKET [CDB_LANES-1:0]  cdb_d;

    logic [NUM_FU-1:0]              grant;
    logic [CDB_LANES-1:0]           lane_vld;
    logic [PTR_W-1:0]               lane_sel [CDB_LANES];
    logic [1:0]                     n_gnt;
    logic [PTR_W:0]                 scan_sum;
    logic [PTR_W-1:0]               scan_idx;
    logic                           scan_ok;
    logic                           rot_hit;
    logic [PTR_W-1:0]               last_rot;

    // Scan from rr_ptr with explicit mod-NUM_FU wrap; grant k lands in lane k.
    always_comb begin
        grant    = '0;
        lane_vld = '0;
        n_gnt    = '0;
        scan_sum = '0;
        scan_idx = '0;
        scan_ok  = 1'b0;
        rot_hit  = 1'b0;
        last_rot = '0;
        for (int l = 0; l < CDB_LANES; l++) begin
            lane_sel[l] = '0;
        end
`ifdef CDB_BRANCH_PRIO_EN
        if (fu_valid[0]) begin
            grant[0]    = 1'b1;
            lane_vld[0] = 1'b1;
            lane_sel[0] = '0;
            n_gnt       = 2'd1;
        end
`endif
        for (int k = 0; k < NUM_FU; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= NUM_FU_EXT) begin
                scan_sum = scan_sum - NUM_FU_EXT;
            end
            scan_idx = scan_sum[PTR_W-1:0];
`ifdef CDB_BRANCH_PRIO_EN
            scan_ok  = (scan_idx != '0);
`else
            scan_ok  = 1'b1;
`endif
            if (scan_ok && fu_valid[scan_idx] && (n_gnt < 2'd3)) begin
                grant[scan_idx]   = 1'b1;
                lane_vld[n_gnt]   = 1'b1;
                lane_sel[n_gnt]   = scan_idx;
                n_gnt             = n_gnt + 2'd1;
                rot_hit           = 1'b1;
                last_rot          = scan_idx;
            end
        end
    end

    always_comb begin
        fu_ready = '0;
        if (reset) begin
            fu_ready = squash_flag ? {NUM_FU{1'b1}} : grant;
        end
    end

    // Pointer only moves past rotation grants; a squash freezes it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rot_hit && !squash_flag) begin
            rr_ptr_d = (last_rot == LAST_FU) ? '0 : last_rot + PTR_W'(1);
        end
    end

    always_comb begin
        for (int l = 0; l < CDB_LANES; l++) begin
            cdb_d[l] = '0;
            if (lane_vld[l] && !squash_flag) begin
                cdb_d[l]       = fu_packet[lane_sel[l]];
                cdb_d[l].valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    assign CDB_packet_out = cdb_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// Module   : tb_cdb_arbiter
// Purpose  : scoreboard bench for cdb_arbiter with NUM_FU = 6.
// Revision : 1.0
// =====================================================================

module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NFU = 6;

    typedef CDB_ROB_PACKET [2:0] lanes_t;

    logic                       clock;
    logic                       reset;
    logic                       squash_flag;
    logic [NFU-1:0]             fu_valid;
    CDB_ROB_PACKET [NFU-1:0]    fu_packet;
    logic [NFU-1:0]             fu_ready;
    CDB_ROB_PACKET [2:0]        CDB_packet_out;

    int     n_cmp;
    int     n_err;
    int     gen [NFU];
    lanes_t exp_q [$];

    cdb_arbiter #(.NUM_FU(NFU)) dut (
        .clock          (clock),
        .reset          (reset),
        .squash_flag    (squash_flag),
        .fu_valid       (fu_valid),
        .fu_packet      (fu_packet),
        .fu_ready       (fu_ready),
        .CDB_packet_out (CDB_packet_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic CDB_ROB_PACKET make_pkt(input int fu, input int g);
        CDB_ROB_PACKET p;
        p             = '0;
        p.tag         = 5'((fu * 5 + g) % 32);
        p.value       = 32'hC0DE_0000 + 32'(fu * 256 + g);
        p.take_branch = (fu == 0);
        p.NPC         = 32'h0000_1000 + 32'(fu * 4);
        p.halt        = (g % 3 == 2);
        return p;
    endfunction

    // Drive one cycle, check the grant, push the expected broadcast and
    // compare it one edge later against the registered lanes.
    task automatic step(input string name, input logic [NFU-1:0] v, input logic sq,
                        input logic [NFU-1:0] er, input int l0, input int l1,
                        input int l2, input int ep);
        lanes_t e;
        int     ls [3];
        ls = '{l0, l1, l2};
        fu_valid    = v;
        squash_flag = sq;
        for (int i = 0; i < NFU; i++) fu_packet[i] = make_pkt(i, gen[i]);
        #1;
        check_val({name, ".ready"}, 128'(fu_ready), 128'(er));
        e = '0;
        for (int l = 0; l < 3; l++) begin
            if (ls[l] >= 0) begin
                e[l]       = make_pkt(ls[l], gen[ls[l]]);
                e[l].valid = 1'b1;
            end
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        squash_flag = 1'b0;
        fu_valid    = '0;
        e = exp_q.pop_front();
        for (int l = 0; l < 3; l++) begin
            check_val($sformatf("%s.lane%0d", name, l), 128'(CDB_packet_out[l]), 128'(e[l]));
        end
        check_val({name, ".ptr"}, 128'(dut.rr_ptr_q), 128'(ep));
        for (int i = 0; i < NFU; i++) begin
            if (er[i] && v[i]) gen[i]++;
        end
    endtask

    task automatic check_cleared(input string name);
        for (int l = 0; l < 3; l++) begin
            check_val($sformatf("%s.lane%0d", name, l), 128'(CDB_packet_out[l]), 128'(0));
        end
        check_val({name, ".ready"}, 128'(fu_ready), 128'(0));
    endtask

    initial begin
        int p_sat;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < NFU; i++) gen[i] = 0;
        reset       = 1'b0;
        squash_flag = 1'b0;
        fu_valid    = 6'b111111;
        for (int i = 0; i < NFU; i++) fu_packet[i] = make_pkt(i, 0);

        #2;
        check_cleared("rst0");
        repeat (2) @(posedge clock);
        #1;
        check_cleared("rst1");
        fu_valid = '0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        check_val("rst.ptr", 128'(dut.rr_ptr_q), 128'(0));

        step("sparse", 6'b000101, 1'b0, 6'b000101, 0, 2, -1, 3);
        step("to0",    6'b100000, 1'b0, 6'b100000, 5, -1, -1, 0);

        step("sat1",   6'b111111, 1'b0, 6'b000111, 0, 1, 2, 3);
`ifdef CDB_BRANCH_PRIO_EN
        step("sat2",   6'b111111, 1'b0, 6'b011001, 0, 3, 4, 5);
        p_sat = 5;
`else
        step("sat2",   6'b111111, 1'b0, 6'b111000, 3, 4, 5, 0);
        p_sat = 0;
`endif
        step("idle",   6'b000000, 1'b0, 6'b000000, -1, -1, -1, p_sat);

        step("to4",    6'b001000, 1'b0, 6'b001000, 3, -1, -1, 4);
`ifdef CDB_BRANCH_PRIO_EN
        step("wrap",   6'b111001, 1'b0, 6'b110001, 0, 4, 5, 0);
`else
        step("wrap",   6'b111001, 1'b0, 6'b110001, 4, 5, 0, 1);
`endif
        step("pend3",  6'b001000, 1'b0, 6'b001000, 3, -1, -1, 4);

        step("squash", 6'b111111, 1'b1, 6'b111111, -1, -1, -1, 4);

        step("to3",    6'b000100, 1'b0, 6'b000100, 2, -1, -1, 3);
`ifdef CDB_BRANCH_PRIO_EN
        step("prio",   6'b111001, 1'b0, 6'b011001, 0, 3, 4, 5);
`else
        step("prio",   6'b111001, 1'b0, 6'b111000, 3, 4, 5, 0);
`endif

        // Mid-cycle asynchronous reset must drop the live broadcast at once.
        fu_valid = 6'b111111;
        #1;
        reset = 1'b0;
        #1;
        check_cleared("arst");
        check_val("arst.ptr", 128'(dut.rr_ptr_q), 128'(0));
        fu_valid = '0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        step("post",   6'b111111, 1'b0, 6'b000111, 0, 1, 2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Schedules functional-unit (FU) completions onto the 3-lane common data bus that feeds the ROB, RS and map table.
- Each cycle it grants up to 3 of `NUM_FU` requesting FUs using a round-robin pointer, compacts the winners into the low lanes and registers them onto `CDB_packet_out`.
- FUs that are not granted hold their result until they are granted.

## Interface
Parameters
- `NUM_FU`, default 6: number of requesting functional units. Must be ≥ 3. FU 0 is the branch unit.
- `CDB_LANES`, fixed 3: CDB width, matching the ROB completion ports.

Ports
- `clock`  in  1  — system clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low; asserted at 0.
- `squash_flag`  in  1  — mispredict flush, same cycle as the ROB squash.
- `fu_valid`  in  `NUM_FU`  — per-FU result-ready request.
- `fu_packet`  in  `CDB_ROB_PACKET [NUM_FU-1:0]`  — per-FU result: tag, value, take_branch, NPC, halt.
- `fu_ready`  out  `NUM_FU`  — per-FU grant, combinational. The result is consumed at the edge where `fu_valid && fu_ready`.
- `CDB_packet_out`  out  `CDB_ROB_PACKET [2:0]`  — registered broadcast to the ROB, RS and map table.

## Operation
- **Request scan:**
  - Scan FU indices `rr_ptr`, `rr_ptr+1`, … mod `NUM_FU`.
  - Grant the first up-to-3 FUs with `fu_valid=1`.
  - Grant k goes to lane k, so valid lanes are always contiguous from lane 0. The ROB relies on this: lane n valid implies lanes 0..n-1 are valid.
- **Grant signal:** `fu_ready[i]=1` iff FU i is granted this cycle. `fu_ready` depends only on `fu_valid`, `rr_ptr` and `squash_flag`, never on itself.
- **Pointer update:**
  - `rr_ptr`, width `$clog2(NUM_FU)`, becomes (index of the last granted FU + 1) mod `NUM_FU`.
  - The pointer is unchanged when nothing is granted.
  - Wraps explicitly mod `NUM_FU`; do not rely on binary overflow.
- **Output register:**
  - Each granted lane loads the winning `fu_packet` with `valid=1`.
  - Ungranted lanes load all-zero, `valid=0`.
- **Producer hold rule:** a requesting FU keeps `fu_valid` high and `fu_packet` stable until it is granted. The arbiter holds no copy of ungranted results.
- **Squash:**
  - In a cycle with `squash_flag=1`, `fu_ready` is all ones (accept-and-discard).
  - At the next edge the output lanes are cleared to `valid=0`.
  - `rr_ptr` is unchanged.
- **Reset:**
  - `rr_ptr=0`.
  - All `CDB_packet_out` lanes are zero, `valid=0`.
  - `fu_ready` is all zeros while `reset=0`.
  - Reset asserted mid-operation discards in-flight output immediately, without waiting for a clock edge.

## Timing
- **Latency:** FU granted at edge N → `CDB_packet_out` shows the result from edge N until edge N+1. Exactly one cycle, no bypass.
- **Throughput:** 3 results per cycle maximum. With `NUM_FU=6` and all FUs requesting continuously, every FU is granted at least once every 2 cycles.
- **No requests:** all lanes invalid next cycle; pointer holds.
- **Simultaneous squash and requests:** squash wins; nothing is broadcast.
- **Wrap-around:** the scan crossing index `NUM_FU-1` continues at 0 within the same cycle.
- **Back-pressure:** none from the ROB. CDB lanes are always accepted.

## Configuration
- Macro: `CDB_BRANCH_PRIO_EN`.
- **Defined:**
  - If FU 0 is valid, it is granted into lane 0 regardless of `rr_ptr`.
  - The remaining lanes fill in round-robin order over FUs 1..`NUM_FU-1`.
  - `rr_ptr` advances only past rotation-granted FUs, so a grant to FU 0 alone leaves the pointer unchanged.
  - Purpose: early mispredict resolution.
- **Undefined:** FU 0 is an ordinary round-robin participant.

## Test plan
All scenarios use `NUM_FU=6`.
1. **Reset:** hold `reset=0` with `fu_valid=6'b111111` → all lanes `valid=0`, `fu_ready=0`. After release, `rr_ptr=0`.
2. **Sparse grant:** `rr_ptr=0`, `fu_valid=6'b000101` → `fu_ready=6'b000101`. Next cycle lane0=FU0 tag, lane1=FU2 tag, lane2 `valid=0`. `rr_ptr=3`.
3. **Saturation:** `rr_ptr=0`, all 6 valid and held.
   - Cycle 1: grants FUs 0,1,2; `rr_ptr=3`.
   - Cycle 2: grants FUs 3,4,5; `rr_ptr=0`.
   - CDB lanes carry tags in that order.
4. **Wrap:** `rr_ptr=4`, `fu_valid=6'b111001` → grants FUs 4,5,0 into lanes 0,1,2; `rr_ptr=1`. FU 3 stays pending and is granted next cycle.
5. **Squash:** all valid with `squash_flag=1` → `fu_ready=6'b111111`. Next cycle all lanes `valid=0`. `rr_ptr` unchanged.
6. **Branch priority:** `rr_ptr=3`, `fu_valid=6'b111001`.
   - With `CDB_BRANCH_PRIO_EN`: lanes carry FUs 0,3,4; `rr_ptr=5`.
   - Without it: lanes carry FUs 3,4,5; `rr_ptr=0`.
